mem_byte_lsu: RTL
=================

// Module: mem_byte_lsu
// PURPOSE
//  Load/store sequencer directly upstream of the byte-wide data memory (8-bit x 2^ADDR_W,
//  rd/wr strobes). Accepts byte/half/word requests from the core over a valid/ready
//  handshake and splits each one into per-byte memory accesses. Assembles read data
//  little-endian with sign/zero extension and returns one response per request.
// PARAMETERS
//  ADDR_W  5  memory byte-address width; must match the memory's addr port
//  RD_LAT  1  cycles from the edge sampling mem_rd=1 to mem_rdata valid (1..3)
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  req_valid     in   1       request present
//  req_ready     out  1       block can accept; high only in IDLE
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       loads: 1 zero-extend, 0 sign-extend
//  req_addr      in   ADDR_W  byte address of LSB
//  req_wdata     in   32      store data; low 8/16/32 bits used
//  resp_valid    out  1       one-cycle pulse, request complete (no backpressure)
//  resp_err      out  1       qualifies resp_valid: misaligned or illegal size
//  resp_rdata    out  32      load result; 0 on store or error response
//  mem_rd        out  1       memory read strobe
//  mem_wr        out  1       memory write strobe
//  mem_addr      out  ADDR_W  memory byte address
//  mem_wdata     out  8       memory write byte
//  mem_rdata     in   8       memory read byte
// BEHAVIOUR
//  - Reset: req_ready=1 after the reset edge. All other outputs 0: resp_*, mem_rd,
//    mem_wr, mem_addr, mem_wdata. State=IDLE.
//  - Accept on the edge with req_valid&&req_ready; all req_* fields latched there.
//    Request fields are ignored while req_ready=0.
//  - N = 1/2/4 bytes for size 00/01/10. Error if size=11 or addr not N-aligned.
//    On error: no mem strobes; resp_valid=1, resp_err=1 in the cycle after accept.
//  - Aligned requests never cross the top of memory (2^ADDR_W divisible by 4).
//  - FSM states: IDLE -> (WR_BYTE | RD_ISSUE | ERR) -> RESP -> IDLE.
//    RD_ISSUE -> RD_WAIT x RD_LAT -> next RD_ISSUE, or RESP after the last byte.
//  - Store: byte i (i=0..N-1, LSB first) at mem_addr=addr+i, mem_wr=1 in cycle i+1
//    after accept. resp_valid in cycle N+1.
//  - Load: byte i has one RD_ISSUE cycle (mem_rd=1, mem_addr=addr+i), then RD_LAT
//    wait cycles with mem_rd=0. mem_rdata is captured at the end of the last wait
//    cycle into bits [8i+7:8i]. resp_valid in cycle N*(1+RD_LAT)+1 after accept.
//  - Extension: byte -> bit 7 or 0 into [31:8]; half -> bit 15 or 0 into [31:16].
//  - mem_rd and mem_wr are never high together. mem_addr/mem_wdata hold their last
//    value when idle.
//  - resp_rdata is valid with resp_valid and holds until the next response.
//  - req_ready returns to 1 in the cycle after RESP, so back-to-back throughput is
//    one request per latency+1 cycles.
//  - Reset mid-operation: abort, no response. Bytes already written stay in memory.
// STRUCTURE
//  - Shared package mem_pkg: SZ_B/SZ_H/SZ_W/SZ_BAD encodings, FSM state encodings,
//    size->byte-count function.
//  - Sub-module lsu_load_ext: combinational {raw32, size, unsigned} -> extended 32b.
//  - Byte counter 2b, wait counter 2b, 32b assembly/shift register.
// TESTING  (bench instantiates the real memory, RD_LAT=1)
//  1. Store byte 0xAA @3 -> mem_wr one cycle, addr=3, wdata=AA; resp ok cycle 2.
//     Load byte unsigned @3 -> resp_rdata=0x000000AA.
//  2. Store word 0x1234ABCD @4 -> bytes CD,AB,34,12 at 4..7, mem_wr cycles 1-4,
//     resp cycle 5. Load word @4 -> 0x1234ABCD at cycle 9.
//  3. Load half signed @6 after step 2 -> 0x00001234. Store half 0x80F0 @8, then load
//     signed -> 0xFFFF80F0; unsigned -> 0x000080F0.
//  4. Load word @5 (misaligned), size=11 @0 -> resp_err=1 next cycle, mem_rd/mem_wr
//     never asserted, rdata=0.
//  5. req_valid held high across two requests; second changes fields while busy
//     -> ignored until req_ready=1, then accepted with the values present then.
//  6. rst during cycle 2 of word store @28 -> no resp, bytes 28,29 written, 30,31
//     untouched, req_ready=1 after the reset edge.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared encodings and helpers for the byte-wide memory LSU.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_BYTE  = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_ERR      = 3'd4,
        ST_RESP     = 3'd5
    } state_e;

    // Number of memory bytes touched by one request of the given size.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    size_nbytes = 3'd1;
            SZ_H:    size_nbytes = 3'd2;
            default: size_nbytes = 3'd4;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : lsu_load_ext
// Purpose  : Sign/zero extension of an assembled little-endian load value.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_ext
);

    logic w_sign_b;
    logic w_sign_h;

    assign w_sign_b = ~i_unsigned & i_raw[7];
    assign w_sign_h = ~i_unsigned & i_raw[15];

    always_comb begin
        o_ext = i_raw;
        case (i_size)
            SZ_B:    o_ext = {{24{w_sign_b}}, i_raw[7:0]};
            SZ_H:    o_ext = {{16{w_sign_h}}, i_raw[15:0]};
            default: o_ext = i_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_byte_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_lsu
// Purpose  : Splits byte/half/word load-store requests into per-byte accesses
//            to a byte-wide memory and returns one response per request.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [1:0] c_wait_last = 2'(RD_LAT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [1:0]        r_last_idx;
    logic [1:0]        r_byte_cnt;
    logic [1:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_data;
    logic [31:0]       r_resp_rdata;
    logic [7:0]        r_mem_wdata;
    logic [31:0]       w_ext;
    logic [31:0]       w_resp_data;
    logic [2:0]        w_req_nbytes;
    logic              w_accept;
    logic              w_req_err;
    logic              w_last_byte;
    logic              w_wait_done;

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_req_nbytes = size_nbytes(req_size);
    assign w_req_err    = (req_size == SZ_BAD)
                       || ((req_size == SZ_H) && req_addr[0])
                       || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
    assign w_last_byte  = (r_byte_cnt == r_last_idx);
    assign w_wait_done  = (r_wait_cnt == c_wait_last);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Errors respond directly from ERR, one cycle after accept, with no strobes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_req_err)   w_state_nxt = ST_ERR;
                    else if (req_we) w_state_nxt = ST_WR_BYTE;
                    else             w_state_nxt = ST_RD_ISSUE;
                end
            end
            ST_WR_BYTE:  if (w_last_byte) w_state_nxt = ST_RESP;
            ST_RD_ISSUE: w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:  if (w_wait_done) w_state_nxt = w_last_byte ? ST_RESP : ST_RD_ISSUE;
            ST_ERR:      w_state_nxt = ST_IDLE;
            ST_RESP:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_size       <= 2'b00;
            r_last_idx   <= 2'd0;
            r_byte_cnt   <= 2'd0;
            r_wait_cnt   <= 2'd0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_data       <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_mem_wdata  <= 8'd0;
        end else begin
            if (w_accept && !w_req_err) begin
                r_we       <= req_we;
                r_uns      <= req_unsigned;
                r_size     <= req_size;
                r_last_idx <= 2'(w_req_nbytes - 3'd1);
                r_byte_cnt <= 2'd0;
                r_wait_cnt <= 2'd0;
                r_addr     <= req_addr;
                r_data     <= 32'd0;
                if (req_we) begin
                    r_wdata     <= req_wdata;
                    r_mem_wdata <= req_wdata[7:0];
                end
            end
            case (r_state)
                ST_WR_BYTE: begin
                    if (!w_last_byte) begin
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        r_mem_wdata <= r_wdata[{r_byte_cnt + 2'd1, 3'b000} +: 8];
                    end
                end
                ST_RD_ISSUE: r_wait_cnt <= 2'd0;
                ST_RD_WAIT: begin
                    if (w_wait_done) begin
                        r_data[{r_byte_cnt, 3'b000} +: 8] <= mem_rdata;
                        if (!w_last_byte) r_byte_cnt <= r_byte_cnt + 2'd1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                ST_RESP: r_resp_rdata <= w_resp_data;
                ST_ERR:  r_resp_rdata <= 32'd0;
                default: ;
            endcase
        end
    end

    lsu_load_ext u_load_ext (
        .i_raw      (r_data),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_ext      (w_ext)
    );

    assign w_resp_data = r_we ? 32'd0 : w_ext;

    assign req_ready  = (r_state == ST_IDLE);
    assign mem_wr     = (r_state == ST_WR_BYTE);
    assign mem_rd     = (r_state == ST_RD_ISSUE);
    assign resp_valid = (r_state == ST_RESP) || (r_state == ST_ERR);
    assign resp_err   = (r_state == ST_ERR);
    // Byte offset never carries past the aligned base, so the address holds when idle.
    assign mem_addr   = r_addr + ADDR_W'(r_byte_cnt);
    assign mem_wdata  = r_mem_wdata;
    assign resp_rdata = (r_state == ST_RESP) ? w_resp_data :
                        (r_state == ST_ERR)  ? 32'd0 : r_resp_rdata;

endmodule
`default_nettype wire
